// File: rtl/skolem_sweep_if.sv
// ============================================================================
// Module      : skolem_sweep_if
// Description : Bundle of host control, formula-side and result signals that
//               connect the Skolem sweep sequencer to its environment.
//               The master side (host/testbench) drives start, abort, y_in and
//               spec_ok. The slave side (the sequencer) drives the swept
//               assignment x_out and all status/result signals.
// Ports       : start, abort          - sweep launch / cancel requests
//               x_out                 - universal-input assignment under test
//               y_in, spec_ok         - formula outputs and evaluator verdict
//               busy, done            - sweep running / completion pulse
//               result_valid, pass    - completed-sweep verdict
//               fail_count            - number of failing vectors
//               first_fail_x/_y/_valid- lowest failing vector and its y
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface skolem_sweep_if #(
    parameter int NUM_X = 4,
    parameter int NUM_Y = 2
);
    logic               start;
    logic               abort;
    logic [NUM_X-1:0]   x_out;
    logic [NUM_Y-1:0]   y_in;
    logic               spec_ok;
    logic               busy;
    logic               done;
    logic               result_valid;
    logic               pass;
    logic [NUM_X:0]     fail_count;
    logic [NUM_X-1:0]   first_fail_x;
    logic [NUM_Y-1:0]   first_fail_y;
    logic               first_fail_valid;

    // Host / formula side
    modport master (
        output start,
        output abort,
        output y_in,
        output spec_ok,
        input  x_out,
        input  busy,
        input  done,
        input  result_valid,
        input  pass,
        input  fail_count,
        input  first_fail_x,
        input  first_fail_y,
        input  first_fail_valid
    );

    // Sequencer side
    modport slave (
        input  start,
        input  abort,
        input  y_in,
        input  spec_ok,
        output x_out,
        output busy,
        output done,
        output result_valid,
        output pass,
        output fail_count,
        output first_fail_x,
        output first_fail_y,
        output first_fail_valid
    );
endinterface

`default_nettype wire

// File: rtl/skolem_sweep_ctrl.sv
// ============================================================================
// Module      : skolem_sweep_ctrl
// Description : Exhaustive sweep sequencer for validating a combinational
//               Skolem-function netlist. Every universal-input assignment x is
//               driven onto the netlist, held for SETTLE_CYCLES cycles, and
//               then the external specification checker's verdict is sampled
//               for one CHECK cycle. Failures are counted and the lowest
//               failing vector (with its y) is captured.
// Ports       : clk      - rising-edge clock
//               rst_n    - asynchronous active-low reset
//               bus      - skolem_sweep_if slave modport:
//                            in : start, abort, y_in, spec_ok
//                            out: x_out, busy, done, result_valid, pass,
//                                 fail_count, first_fail_x, first_fail_y,
//                                 first_fail_valid
// Parameters  : NUM_X         - universal input width (1..16)
//               NUM_Y         - Skolem output width (>=1)
//               SETTLE_CYCLES - cycles x is held before sampling (>=1)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module skolem_sweep_ctrl #(
    parameter int NUM_X         = 4,
    parameter int NUM_Y         = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    skolem_sweep_if.slave    bus
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------------
    generate
        if (NUM_X < 1 || NUM_X > 16) begin : g_bad_num_x
            $error("skolem_sweep_ctrl: NUM_X must be in 1..16");
        end
        if (NUM_Y < 1) begin : g_bad_num_y
            $error("skolem_sweep_ctrl: NUM_Y must be >= 1");
        end
        if (SETTLE_CYCLES < 1) begin : g_bad_settle
            $error("skolem_sweep_ctrl: SETTLE_CYCLES must be >= 1");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The settle counter only has to hold SETTLE_CYCLES-1.
    localparam int                CNT_W      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [NUM_X-1:0]  X_LAST     = {NUM_X{1'b1}};
    localparam logic [NUM_X-1:0]  X_ONE      = NUM_X'(1);
    localparam logic [NUM_X:0]    FC_ONE     = (NUM_X + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [NUM_X-1:0]   x_q,      x_d;
    logic [NUM_X:0]     fc_q,     fc_d;
    logic [NUM_X-1:0]   ffx_q,    ffx_d;
    logic [NUM_Y-1:0]   ffy_q,    ffy_d;
    logic               ffv_q,    ffv_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;
    logic               rv_q,     rv_d;
    logic               pass_q,   pass_d;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            fc_q    <= '0;
            ffx_q   <= '0;
            ffy_q   <= '0;
            ffv_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rv_q    <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            fc_q    <= fc_d;
            ffx_q   <= ffx_d;
            ffy_q   <= ffy_d;
            ffv_q   <= ffv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rv_q    <= rv_d;
            pass_q  <= pass_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        fc_d    = fc_q;
        ffx_d   = ffx_q;
        ffy_d   = ffy_q;
        ffv_d   = ffv_q;
        rv_d    = rv_q;
        pass_d  = pass_q;

        unique case (state_q)
            ST_IDLE: begin
                // start together with abort is treated as a cancelled launch.
                if (bus.start && !bus.abort) begin
                    state_d = ST_SETTLE;
                    cnt_d   = CNT_RELOAD;
                    x_d     = '0;
                    fc_d    = '0;
                    ffx_d   = '0;
                    ffy_d   = '0;
                    ffv_d   = 1'b0;
                    rv_d    = 1'b0;
                    pass_d  = 1'b0;
                end
            end

            ST_SETTLE: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    rv_d    = 1'b0;
                    pass_d  = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_CHECK: begin
                if (bus.abort) begin
                    // The verdict sampled on this edge is thrown away.
                    state_d = ST_IDLE;
                    rv_d    = 1'b0;
                    pass_d  = 1'b0;
                end else begin
                    if (!bus.spec_ok) begin
                        fc_d = fc_q + FC_ONE;
                        // Vectors are swept in ascending order, so the first
                        // failure seen is the lowest failing x.
                        if (!ffv_q) begin
                            ffx_d = x_q;
                            ffy_d = bus.y_in;
                            ffv_d = 1'b1;
                        end
                    end
                    if (x_q == X_LAST) begin
                        state_d = ST_DONE;
                        rv_d    = 1'b1;
                        // Uses the count including this last vector.
                        pass_d  = (fc_d == '0);
                    end else begin
                        state_d = ST_SETTLE;
                        x_d     = x_q + X_ONE;
                        cnt_d   = CNT_RELOAD;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status flags are registered copies of the state being entered so
        // that they line up cycle-exactly with the state itself.
        busy_d = (state_d == ST_SETTLE) || (state_d == ST_CHECK);
        done_d = (state_d == ST_DONE);
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.x_out            = x_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.result_valid     = rv_q;
    assign bus.pass             = pass_q;
    assign bus.fail_count       = fc_q;
    assign bus.first_fail_x     = ffx_q;
    assign bus.first_fail_y     = ffy_q;
    assign bus.first_fail_valid = ffv_q;

endmodule

`default_nettype wire

// File: doc/skolem_sweep_ctrl.md
# skolem_sweep_ctrl

Sequencer that exhaustively checks a combinational Skolem-function netlist against its specification. It drives every universal-input assignment x onto the netlist and waits a fixed settle time. It then samples the external specification checker's verdict on (x, y) and accumulates pass/fail statistics. It sits between the synthesized `SKOLEMFORMULA` instance plus a spec-evaluator cone and the host/testbench that launches validation runs.

## Interface

Parameters:
- `NUM_X`, default 4: number of universal inputs (width of x); sweep covers 2^NUM_X vectors; legal 1..16.
- `NUM_Y`, default 2: number of Skolem outputs (width of y); legal ≥1.
- `SETTLE_CYCLES`, default 1: cycles x is held before sampling; legal ≥1.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: launch a sweep; sampled only in IDLE.
- `abort` input 1: cancel a running sweep.
- `x_out` output NUM_X: current assignment driven to the formula's universal inputs.
- `y_in` input NUM_Y: Skolem outputs returned by the formula; captured on failure only.
- `spec_ok` input 1: external evaluator, high when F(x_out, y_in) holds; combinational from x_out/y_in.
- `busy` output 1: high in SETTLE and CHECK.
- `done` output 1: one-cycle pulse at sweep completion.
- `result_valid` output 1: results below belong to a completed sweep.
- `pass` output 1: completed sweep had zero failures.
- `fail_count` output NUM_X+1: number of failing vectors; max 2^NUM_X.
- `first_fail_x` output NUM_X: lowest failing x.
- `first_fail_y` output NUM_Y: y_in at that vector.
- `first_fail_valid` output 1: at least one failure recorded.

## Operation

- States: IDLE, SETTLE, CHECK, DONE.
- **Reset (async, rst_n=0):**
  - State goes to IDLE.
  - `x_out`=0, `busy`=0, `done`=0, `result_valid`=0, `pass`=0, `fail_count`=0, `first_fail_x`=0, `first_fail_y`=0, `first_fail_valid`=0.
  - Settle counter resets to 0.
- **IDLE:**
  - On `start`=1 and `abort`=0: clear `fail_count`, `first_fail_*`, `result_valid`, `pass`; set `x_out`=0; load settle counter with SETTLE_CYCLES-1; go to SETTLE.
  - If `abort`=1, stay in IDLE.
- **SETTLE:**
  - Decrement the counter each cycle.
  - When the counter is 0, go to CHECK.
  - The state lasts exactly SETTLE_CYCLES cycles.
- **CHECK (one cycle):**
  - Sample `spec_ok` on the edge that leaves CHECK.
  - If `spec_ok`=0: `fail_count`+=1. If `first_fail_valid`=0, also capture `x_out`→`first_fail_x`, `y_in`→`first_fail_y`, and set `first_fail_valid`.
  - If `x_out`=2^NUM_X-1, go to DONE. Otherwise increment `x_out`, reload the counter, and go to SETTLE.
- **DONE (one cycle):**
  - `done`=1.
  - `result_valid`=1 and `pass`=(`fail_count`==0), both held until the next accepted `start` or reset.
  - Next state is IDLE.
- **`abort`:**
  - In SETTLE or CHECK, go to IDLE on the next edge.
  - No `done` pulse; `result_valid`=0, `pass`=0.
  - The CHECK sample on the abort edge is discarded.
  - `x_out` keeps its last value.
- `start` is ignored outside IDLE.
- `x_out` never wraps past 2^NUM_X-1. `fail_count` is wide enough that it cannot overflow.

## Timing

- `start` is sampled at edge k. The state is SETTLE after edge k, and `x_out`=0 is valid in that cycle.
- Each vector takes SETTLE_CYCLES+1 cycles.
- `done` is high in the cycle after edge k+2^NUM_X·(SETTLE_CYCLES+1).
  - Defaults: after edge k+32.
- `result_valid` and `pass` rise together with `done`.
- The `fail_count` update for a vector is visible the cycle after its CHECK.
- `start` held high continuously gives back-to-back sweeps separated by exactly one IDLE cycle after DONE.
- Asynchronous reset mid-sweep forces all outputs to their reset values immediately. No `done` pulse is produced.
- All outputs are registered. `spec_ok` must settle within the SETTLE_CYCLES window; it is not sampled during SETTLE.

## Test plan

- **Correct formula, defaults:** spec_ok = (y_in[1]^y_in[0]) correct for every x (bench model of the 4-input XOR spec with a correct formula); start at edge 0. Required: `done` after edge 32, `pass`=1, `fail_count`=0, `first_fail_valid`=0.
- **Stuck y:** y_in=2'b00 with a spec that fails for x with odd parity. Required: `fail_count`=8, `first_fail_x`=4'b0001, `first_fail_y`=2'b00, `pass`=0.
- **Abort:** `abort` pulsed while `x_out`=5 in CHECK. Required: IDLE next cycle, no `done`, `result_valid`=0, `x_out`=5, `busy`=0.
- **Reset mid-sweep:** `rst_n` low asynchronously at `x_out`=9, between edges. Required: all outputs 0 immediately; a new `start` then completes normally.
- **SETTLE_CYCLES=3, defaults otherwise:** Required: `done` after edge k+64; `spec_ok` glitch during SETTLE cycles is not counted.
- **Start held high for two sweeps:** Required: second sweep's `x_out`=0 appears two cycles after the first `done` cycle begins (DONE, IDLE, SETTLE); `start`/`abort` together in IDLE does not launch.
